// File: rtl/airlock_pkg.sv
// ============================================================================
// airlock_pkg : state encoding and default timing shared by both airlock sides
// Rev 1.0
// ============================================================================
`default_nettype none

package airlock_pkg;

  localparam int unsigned DWELL_TICKS_DEF   = 5;
  localparam int unsigned TIMEOUT_TICKS_DEF = 20;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_WAIT_DWELL = 4'd1;
  localparam logic [3:0] ST_PRESS      = 4'd2;
  localparam logic [3:0] ST_OPEN_OUT   = 4'd3;
  localparam logic [3:0] ST_ENTER      = 4'd4;
  localparam logic [3:0] ST_CLOSE_OUT  = 4'd5;
  localparam logic [3:0] ST_EVAC       = 4'd6;
  localparam logic [3:0] ST_OPEN_IN    = 4'd7;
  localparam logic [3:0] ST_EXIT       = 4'd8;
  localparam logic [3:0] ST_CLOSE_IN   = 4'd9;
  localparam logic [3:0] ST_FAULT      = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE       = ST_IDLE,
    S_WAIT_DWELL = ST_WAIT_DWELL,
    S_PRESS      = ST_PRESS,
    S_OPEN_OUT   = ST_OPEN_OUT,
    S_ENTER      = ST_ENTER,
    S_CLOSE_OUT  = ST_CLOSE_OUT,
    S_EVAC       = ST_EVAC,
    S_OPEN_IN    = ST_OPEN_IN,
    S_EXIT       = ST_EXIT,
    S_CLOSE_IN   = ST_CLOSE_IN,
    S_FAULT      = ST_FAULT
  } state_t;

  // Sensor-wait states guarded by the watchdog.
  function automatic logic is_watched(input state_t s);
    return (s >= S_PRESS) && (s <= S_CLOSE_IN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/airlock_arrival_if.sv
// ============================================================================
// airlock_arrival_if : request, interlock, sensor and actuator bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface airlock_arrival_if;
  logic tick;
  logic arrive_req;
  logic departing;
  logic pressurized;
  logic evacuated;
  logic outer_door_open;
  logic inner_door_open;
  logic boat_in;
  logic boat_out;
  logic arriving;
  logic pressurize_cmd;
  logic evacuate_cmd;
  logic outer_open_cmd;
  logic inner_open_cmd;
  logic done;
  logic fault;

  modport master (
    input  tick, arrive_req, departing, pressurized, evacuated,
           outer_door_open, inner_door_open, boat_in, boat_out,
    output arriving, pressurize_cmd, evacuate_cmd, outer_open_cmd,
           inner_open_cmd, done, fault
  );

  modport slave (
    output tick, arrive_req, departing, pressurized, evacuated,
           outer_door_open, inner_door_open, boat_in, boat_out,
    input  arriving, pressurize_cmd, evacuate_cmd, outer_open_cmd,
           inner_open_cmd, done, fault
  );
endinterface

`default_nettype wire

// File: rtl/airlock_tick_counter.sv
// ============================================================================
// airlock_tick_counter : loadable down-counter of time-base ticks
// Rev 1.0
// ============================================================================
`default_nettype none

module airlock_tick_counter #(
  parameter int unsigned MAX   = 5,
  parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  input  wire logic             tick,
  output logic                  zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Flags the tick that takes the count to zero, so the owner can act on that same edge.
  assign zero = tick && (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/airlock_arrival.sv
// ============================================================================
// airlock_arrival : arrival-side airlock sequencer (outer door in, inner door out)
// Optional watchdog/FAULT state: define ARRIVAL_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module airlock_arrival
  import airlock_pkg::*;
#(
  parameter int unsigned DWELL_TICKS   = DWELL_TICKS_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst,
  airlock_arrival_if.master bus
);

  localparam int unsigned DWELL_W = $clog2(DWELL_TICKS + 1);

  state_t state;
  state_t next_state;
  logic   dwell_load;
  logic   dwell_zero;

  logic arriving_reg, press_reg, evac_reg, outer_reg, inner_reg, done_reg;
  logic arriving_nxt, press_nxt, evac_nxt, outer_nxt, inner_nxt, done_nxt;

  // Held loaded outside the dwell so the full count is present on entry.
  assign dwell_load = (state != S_WAIT_DWELL);

  airlock_tick_counter #(
    .MAX   (DWELL_TICKS),
    .WIDTH (DWELL_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load       (dwell_load),
    .load_value (DWELL_W'(DWELL_TICKS)),
    .tick       (bus.tick),
    .zero       (dwell_zero)
  );

`ifdef ARRIVAL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_TICKS + 1);

  logic wd_load;
  logic wd_zero;
  logic fault_reg;

  assign wd_load = (next_state != state) || !is_watched(state);

  airlock_tick_counter #(
    .MAX   (TIMEOUT_TICKS),
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load       (wd_load),
    .load_value (WD_W'(TIMEOUT_TICKS)),
    .tick       (bus.tick),
    .zero       (wd_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= (next_state == S_FAULT);
    end
  end

  assign bus.fault = fault_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_TICKS != 0);
  assign bus.fault      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (bus.arrive_req && !bus.departing) next_state = S_WAIT_DWELL;
      S_WAIT_DWELL: if (dwell_zero)                       next_state = S_PRESS;
      S_PRESS:      if (bus.pressurized)                  next_state = S_OPEN_OUT;
      S_OPEN_OUT:   if (bus.outer_door_open)              next_state = S_ENTER;
      S_ENTER:      if (bus.boat_in)                      next_state = S_CLOSE_OUT;
      S_CLOSE_OUT:  if (!bus.outer_door_open)             next_state = S_EVAC;
      S_EVAC:       if (bus.evacuated)                    next_state = S_OPEN_IN;
      S_OPEN_IN:    if (bus.inner_door_open)              next_state = S_EXIT;
      S_EXIT:       if (bus.boat_out)                     next_state = S_CLOSE_IN;
      S_CLOSE_IN:   if (!bus.inner_door_open)             next_state = S_IDLE;
      S_FAULT:      next_state = S_FAULT;
      default:      next_state = S_IDLE;
    endcase
`ifdef ARRIVAL_TIMEOUT_EN
    // A sensor arriving on the expiry edge still wins over the timeout.
    if (is_watched(state) && (next_state == state) && wd_zero) begin
      next_state = S_FAULT;
    end
`endif

    arriving_nxt = (next_state != S_IDLE) && (next_state != S_FAULT);
    press_nxt    = (next_state == S_PRESS);
    outer_nxt    = (next_state == S_OPEN_OUT) || (next_state == S_ENTER);
    evac_nxt     = (next_state == S_EVAC);
    inner_nxt    = (next_state == S_OPEN_IN) || (next_state == S_EXIT);
    done_nxt     = (state == S_CLOSE_IN) && (next_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      arriving_reg <= 1'b0;
      press_reg    <= 1'b0;
      evac_reg     <= 1'b0;
      outer_reg    <= 1'b0;
      inner_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state        <= next_state;
      arriving_reg <= arriving_nxt;
      press_reg    <= press_nxt;
      evac_reg     <= evac_nxt;
      outer_reg    <= outer_nxt;
      inner_reg    <= inner_nxt;
      done_reg     <= done_nxt;
    end
  end

  assign bus.arriving       = arriving_reg;
  assign bus.pressurize_cmd = press_reg;
  assign bus.evacuate_cmd   = evac_reg;
  assign bus.outer_open_cmd = outer_reg;
  assign bus.inner_open_cmd = inner_reg;
  assign bus.done           = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_airlock_arrival.sv
// ============================================================================
// tb_airlock_arrival : randomized arrival runs against a plant model and the
// expected phase order of an arrival.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_airlock_arrival;

  localparam int DWELL = 5;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  airlock_arrival_if bus ();

  airlock_arrival #(
    .DWELL_TICKS   (DWELL),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Plant state: each sensor answers lat cycles after its command is seen.
  int lat;
  int pc, ec, oc, ocl, ic, icl, bic, boc;
  bit stuck_outer;

  // Observations of one arrival, as {arriving, press, outer, evac, inner} phases.
  logic [4:0] phases[$];
  logic [4:0] exp_phases[8];
  int  dwell_ticks, dwell_at_press, done_cnt, press_cycles;
  bit  saw_press, finished, stopped, done_bad, arriving_after;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (($countones({bus.pressurize_cmd, bus.evacuate_cmd, bus.outer_open_cmd, bus.inner_open_cmd}) > 1)
          || (bus.pressurize_cmd && bus.evacuate_cmd)) begin
        errors++;
        $display("FAIL cmd_exclusive: cmds(p,e,o,i)=%b%b%b%b, required at most one high",
                 bus.pressurize_cmd, bus.evacuate_cmd, bus.outer_open_cmd, bus.inner_open_cmd);
      end
`ifndef ARRIVAL_TIMEOUT_EN
      checks++;
      if (bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_tied: fault=%b, required 0", bus.fault);
      end
`endif
    end
  end

  function automatic logic [6:0] all_outs();
    return {bus.arriving, bus.pressurize_cmd, bus.evacuate_cmd, bus.outer_open_cmd,
            bus.inner_open_cmd, bus.done, bus.fault};
  endfunction

  function automatic logic [4:0] phase_vec();
    return {bus.arriving, bus.pressurize_cmd, bus.outer_open_cmd, bus.evacuate_cmd,
            bus.inner_open_cmd};
  endfunction

  function automatic bit phases_ok();
    if (phases.size() != 8) return 1'b0;
    for (int k = 0; k < 8; k++) if (phases[k] !== exp_phases[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic plant_reset(input bit pre_press);
    bus.pressurized     = pre_press;
    bus.evacuated       = !pre_press;
    bus.outer_door_open = 1'b0;
    bus.inner_door_open = 1'b0;
    bus.boat_in         = 1'b0;
    bus.boat_out        = 1'b0;
    pc = 0; ec = 0; oc = 0; ocl = 0; ic = 0; icl = 0; bic = 0; boc = 0;
    stuck_outer = 1'b0;
  endtask

  // Advance one clock, then let the plant react to the commands just registered.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.pressurize_cmd) pc++; else pc = 0;
    if (pc >= lat) begin bus.pressurized = 1'b1; bus.evacuated = 1'b0; end
    if (bus.evacuate_cmd) ec++; else ec = 0;
    if (ec >= lat) begin bus.evacuated = 1'b1; bus.pressurized = 1'b0; end
    if (bus.outer_open_cmd) begin
      oc++; ocl = 0;
      if (oc >= lat && !stuck_outer) bus.outer_door_open = 1'b1;
    end else begin
      oc = 0;
      if (bus.outer_door_open) begin ocl++; if (ocl >= lat) bus.outer_door_open = 1'b0; end
    end
    if (bus.inner_open_cmd) begin
      ic++; icl = 0;
      if (ic >= lat) bus.inner_door_open = 1'b1;
    end else begin
      ic = 0;
      if (bus.inner_door_open) begin icl++; if (icl >= lat) bus.inner_door_open = 1'b0; end
    end
    if (bus.outer_open_cmd && bus.outer_door_open) bic++; else bic = 0;
    if (bic >= lat) bus.boat_in = 1'b1;
    if (bus.inner_open_cmd && bus.inner_door_open) boc++; else boc = 0;
    if (boc >= lat) begin bus.boat_out = 1'b1; bus.boat_in = 1'b0; end
  endtask

  // Drives one arrival from IDLE and records what the DUT did.
  task automatic run_arrival(input bit rand_tick, input bit rand_noise, input bit stop_at_evac);
    logic [4:0] vec;
    bit tk;
    phases.delete();
    dwell_ticks = 0; dwell_at_press = -1; done_cnt = 0; press_cycles = 0;
    saw_press = 0; finished = 0; stopped = 0; done_bad = 0; arriving_after = 0;
    bus.arrive_req = 1'b1;
    bus.departing  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      vec = phase_vec();
      if (vec != 5'b0 && (phases.size() == 0 || vec != phases[$])) phases.push_back(vec);
      else if (vec == 5'b0 && phases.size() != 0 && phases[$] != 5'b0) phases.push_back(vec);
      if (bus.done) begin
        done_cnt++;
        if (bus.arriving) done_bad = 1'b1;
      end
      if (vec == 5'b11000) press_cycles++;
      if (vec == 5'b11000 && !saw_press) begin saw_press = 1'b1; dwell_at_press = dwell_ticks; end
      if (stop_at_evac && vec == 5'b10010) begin stopped = 1'b1; break; end
      tk = rand_tick ? ($urandom_range(0, 2) == 0) : (cyc % 2 == 0);
      bus.tick = tk;
      if (tk && vec == 5'b10000 && phases.size() == 1) dwell_ticks++;
      if (phases.size() > 1 && vec == 5'b0) begin finished = 1'b1; break; end
      // Mid-sequence request and interlock activity must be ignored.
      if (rand_noise) begin
        bus.arrive_req = 1'($urandom_range(0, 1));
        bus.departing  = 1'($urandom_range(0, 1));
      end else begin
        bus.arrive_req = 1'b0;
      end
    end
    bus.arrive_req = 1'b0;
    bus.departing  = 1'b0;
    if (finished) begin
      for (int k = 0; k < 3; k++) begin
        step();
        if (bus.done) done_cnt++;
        if (bus.arriving) arriving_after = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] o;
    rst = 1'b1;
    bus.tick = 1'b1; bus.arrive_req = 1'b1; bus.departing = 1'b0;
    lat = 3;
    plant_reset(1'b0);
    repeat (3) step();
    o = all_outs();
    checks++;
    if (o !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%b, required 0000000", o);
    end
    bus.arrive_req = 1'b0;
    bus.tick = 1'b0;
    rst = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic check_arrival(input string name, input bit check_dwell);
    checks++;
    if (!finished || !phases_ok()) begin
      errors++;
      $display("FAIL %s_phases: finished=%0d phases=%0d first=%b last=%b, required 8 phases in arrival order",
               name, finished, phases.size(), (phases.size() > 0) ? phases[0] : 5'bx,
               (phases.size() > 0) ? phases[$] : 5'bx);
    end
    if (check_dwell) begin
      checks++;
      if (dwell_at_press != DWELL) begin
        errors++;
        $display("FAIL %s_dwell: ticks in dwell=%0d, required %0d", name, dwell_at_press, DWELL);
      end
    end
    checks++;
    if (done_cnt != 1 || done_bad) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d with_arriving=%0d, required 1 and 0", name, done_cnt, done_bad);
    end
    checks++;
    if (arriving_after) begin
      errors++;
      $display("FAIL %s_after: arriving=1 after done, required 0", name);
    end
  endtask

  task automatic test_full_arrival();
    lat = 3;
    plant_reset(1'b0);
    run_arrival(1'b0, 1'b0, 1'b0);
    check_arrival("full", 1'b1);
  endtask

  task automatic test_random_arrivals();
    for (int n = 0; n < 4; n++) begin
      lat = $urandom_range(1, 4);
      plant_reset(1'b0);
      run_arrival(1'b1, 1'b1, 1'b0);
      check_arrival("random", 1'b1);
    end
  endtask

  task automatic test_departing_interlock();
    int bad;
    lat = 3;
    plant_reset(1'b0);
    bus.arrive_req = 1'b1;
    bus.departing  = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bus.tick = 1'($urandom_range(0, 1));
      step();
      if (all_outs() !== 7'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL interlock_hold: %0d cycles with outputs active, required 0", bad);
    end
    bus.departing = 1'b0;
    step();
    checks++;
    if (bus.arriving !== 1'b1) begin
      errors++;
      $display("FAIL interlock_release: arriving=%b one cycle after departing fell, required 1", bus.arriving);
    end
    bus.arrive_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_in_evac();
    logic [6:0] o;
    lat = 2;
    plant_reset(1'b0);
    run_arrival(1'b1, 1'b0, 1'b1);
    checks++;
    if (!stopped || bus.evacuate_cmd !== 1'b1) begin
      errors++;
      $display("FAIL evac_reach: reached=%0d evacuate_cmd=%b, required 1 and 1", stopped, bus.evacuate_cmd);
    end
    rst = 1'b1;
    step();
    o = all_outs();
    checks++;
    if (o !== 7'b0) begin
      errors++;
      $display("FAIL evac_reset: outputs=%b, required 0000000", o);
    end
    rst = 1'b0;
    plant_reset(1'b0);
    run_arrival(1'b1, 1'b0, 1'b0);
    check_arrival("restart", 1'b1);
  endtask

  task automatic test_prepressurized();
    lat = 3;
    plant_reset(1'b1);
    run_arrival(1'b1, 1'b0, 1'b0);
    checks++;
    if (press_cycles != 1) begin
      errors++;
      $display("FAIL prepress_cycles: pressurize_cmd cycles=%0d, required 1", press_cycles);
    end
    check_arrival("prepress", 1'b0);
  endtask

`ifdef ARRIVAL_TIMEOUT_EN
  task automatic test_timeout();
    logic [6:0] o;
    int ticks_open, fault_ticks, held_bad;
    bit tk, seen;
    lat = 2;
    plant_reset(1'b0);
    stuck_outer = 1'b1;
    bus.arrive_req = 1'b1;
    ticks_open = 0; fault_ticks = -1; seen = 0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      step();
      bus.arrive_req = 1'b0;
      if (bus.fault) begin
        seen = 1'b1;
        fault_ticks = ticks_open;
        o = all_outs();
      end else begin
        tk = ($urandom_range(0, 1) == 1);
        bus.tick = tk;
        if (tk && bus.outer_open_cmd) ticks_open++;
      end
    end
    checks++;
    if (!seen || fault_ticks != TMO) begin
      errors++;
      $display("FAIL timeout_ticks: fault seen=%0d after %0d ticks in OPEN_OUT, required 1 after %0d",
               seen, fault_ticks, TMO);
    end
    checks++;
    if (seen && o !== 7'b0000001) begin
      errors++;
      $display("FAIL timeout_outputs: outputs=%b, required 0000001", o);
    end
    held_bad = 0;
    for (int k = 0; k < 12; k++) begin
      bus.tick = 1'($urandom_range(0, 1));
      bus.arrive_req = 1'($urandom_range(0, 1));
      bus.outer_door_open = 1'($urandom_range(0, 1));
      step();
      if (all_outs() !== 7'b0000001) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL timeout_hold: %0d cycles left FAULT before rst, required 0", held_bad);
    end
    bus.arrive_req = 1'b0;
    rst = 1'b1;
    step();
    o = all_outs();
    checks++;
    if (o !== 7'b0) begin
      errors++;
      $display("FAIL timeout_clear: outputs=%b after rst, required 0000000", o);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    exp_phases = '{5'b10000, 5'b11000, 5'b10100, 5'b10000,
                   5'b10010, 5'b10001, 5'b10000, 5'b00000};
    test_reset();
    test_full_arrival();
    test_random_arrivals();
    test_departing_interlock();
    test_reset_in_evac();
    test_prepressurized();
`ifdef ARRIVAL_TIMEOUT_EN
    test_timeout();
`endif
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
